can_opb_slave: RTL and testbench
================================

# can_opb_slave

OPB slave front-end that sits directly upstream of the four-channel CAN interface. It turns OPB bus transactions into the single-cycle `CAN_RE`/`CAN_WE` strobes, address and write data that the CAN interface consumes. It waits a fixed read latency, captures `CAN_DO`, and closes every transaction with an OPB acknowledge. Illegal channel selects inside the CAN window get an error acknowledge; addresses outside the window are ignored.

## Interface
Parameters:
- `C_BASEADDR`, 32'h0000_0000: base of the CAN window; `OPB_ABus[31:15]` must equal `C_BASEADDR[31:15]`.
- `RD_LAT`, 2: edges from the strobe-assert edge to the `CAN_DO` capture edge; legal range 1..15.

Ports. Clock and reset are decided: one clock, `OPB_CLK`; reset `OPB_RST_N` is asynchronous and active-low.
- `OPB_CLK` in 1: sole clock.
- `OPB_RST_N` in 1: asynchronous, active-low reset.
- `OPB_select` in 1: OPB transaction request.
- `OPB_RNW` in 1: 1 = read, 0 = write.
- `OPB_ABus` in 32: address.
- `OPB_DBus` in 32: write data.
- `Sl_xferAck` out 1: transfer acknowledge, one-cycle pulse.
- `Sl_errAck` out 1: error acknowledge, pulses together with `Sl_xferAck`.
- `Sl_toutSup` out 1: timeout suppress while a transaction is in flight.
- `Sl_DBus` out 32: read data; zero whenever `Sl_xferAck` is low (OR-bus rule).
- `CAN_ADDR` out 32: registered address to the CAN interface.
- `CAN_DI` out 32: registered write data.
- `CAN_RE` out 1: one-cycle read strobe.
- `CAN_WE` out 1: one-cycle write strobe.
- `CAN_DO` in 32: read data returned by the CAN interface.

## Operation
- In-window: `OPB_select` high and `OPB_ABus[31:15]` equals `C_BASEADDR[31:15]`.
- Hit: in-window and `OPB_ABus[14:11]` is one-hot. 0001 = CAN1, 0010 = CAN2, 0100 = CAN3, 1000 = CAN4.
- Bad: in-window but `[14:11]` not one-hot (0000, or two or more bits set).
- Not in-window: the block stays in IDLE and drives nothing.
- States and transitions:
  - IDLE → STB on hit. Register `CAN_ADDR`/`CAN_DI`; assert `CAN_WE` (write) or `CAN_RE` (read).
  - IDLE → ERR on bad.
  - STB → ACK for a write; STB → WAIT for a read.
  - WAIT counts down from `RD_LAT-1`. At zero it captures `CAN_DO` into `Sl_DBus` and moves to ACK.
  - If `RD_LAT=1`, STB → ACK directly for reads, with the capture at the STB→ACK edge.
  - ACK: `Sl_xferAck=1` for one cycle, then DONE.
  - ERR: `Sl_xferAck=1`, `Sl_errAck=1`, `Sl_DBus=0` for one cycle, then DONE. No strobe is issued.
  - DONE → IDLE once `OPB_select` is sampled low. Select still high in DONE never starts a new transaction.
- Master abort: `OPB_select` sampled low in STB or WAIT → IDLE. No ack; the captured data is discarded. A strobe that was already asserted still lasts exactly one cycle.
- `Sl_toutSup` is high in STB and WAIT.
- `CAN_ADDR`/`CAN_DI` hold their values until the next hit.

## Timing
- E0 is the edge that samples a hit in IDLE. Strobe is high in the cycle after E0.
- Write: `Sl_xferAck` high in the cycle after E1. Latency from select to ack is 2 cycles.
- Read: `CAN_DO` is captured at edge E(`RD_LAT`). `Sl_xferAck` and `Sl_DBus` are valid in the following cycle, giving a latency of `RD_LAT+1` cycles (3 by default).
- Error: ack pulse in the cycle after E0.
- Minimum spacing between transactions: the cycle after ack (DONE), plus one IDLE sample.
- Reset values, all outputs: `Sl_xferAck=0`, `Sl_errAck=0`, `Sl_toutSup=0`, `Sl_DBus=0`, `CAN_ADDR=0`, `CAN_DI=0`, `CAN_RE=0`, `CAN_WE=0`. State resets to IDLE and the counter to 0.
- Reset asserted mid-transaction clears all of the above asynchronously; no ack is issued.
- All outputs are registered.
- Counter width is 4 bits.

## Structure
- Shared package `can_if_pkg`:
  - state encoding typedef;
  - channel select constants `CAN1_SEL`..`CAN4_SEL` (4'b0001..4'b1000);
  - window field positions (`[31:15]`, `[14:11]`);
  - an `is_onehot4` function, reused by the CAN interface.
- Single module; no sub-module is warranted. The latency counter and the decode stay inline.

## Test plan
- Write 0x0000_0800 / 0x1234_5678 → `CAN_WE` one cycle after E0 with `CAN_ADDR=0x800` and `CAN_DI=0x12345678`. `Sl_xferAck` one cycle later, `Sl_errAck=0`.
- Read 0x0000_2000 with `CAN_DO=0x55AA55AA` at E2 → `Sl_xferAck` and `Sl_DBus=0x55AA55AA` for exactly one cycle, 3 cycles after select. `Sl_DBus` is 0 before and after.
- Read 0x0000_1800 (`[14:11]`=0011) and 0x0000_0000 → `Sl_xferAck` and `Sl_errAck` one cycle after select. No `CAN_RE`, `Sl_DBus=0`.
- Access to 0x0001_0800 with `C_BASEADDR=0` → no strobe, no ack, `Sl_toutSup=0`.
- Read 0x0000_4000, select dropped after the strobe cycle → no ack; next write to 0x0000_0804 completes normally. Separately, hold select high through DONE → only one strobe is issued.
- Assert `OPB_RST_N` low during WAIT → all outputs 0 immediately. After release, a read of 0x0000_0800 completes with 3-cycle latency.

Source files
------------

// File: rtl/can_if_pkg.sv
// Shared definitions for the OPB-to-CAN front-end and the four-channel CAN interface.
// Contents:
//   can_opb_state_e - transaction FSM state encoding
//   CAN1_SEL..4_SEL - channel select codes carried in OPB_ABus[14:11]
//   WIN_*/SEL_*     - bit positions of the window compare and channel-select fields
//   is_onehot4      - legal channel-select test
package can_if_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStb,
      StWait,
      StAck,
      StErr,
      StDone
   } can_opb_state_e;

   localparam logic [3:0] CAN1_SEL = 4'b0001;
   localparam logic [3:0] CAN2_SEL = 4'b0010;
   localparam logic [3:0] CAN3_SEL = 4'b0100;
   localparam logic [3:0] CAN4_SEL = 4'b1000;

   localparam int unsigned WIN_MSB = 31;
   localparam int unsigned WIN_LSB = 15;
   localparam int unsigned SEL_MSB = 14;
   localparam int unsigned SEL_LSB = 11;

   localparam int unsigned CNT_W = 4;

   // A select field is legal only when it names exactly one channel.
   function automatic logic is_onehot4(input logic [3:0] sel);
      logic hit;
      case (sel)
         CAN1_SEL, CAN2_SEL, CAN3_SEL, CAN4_SEL: hit = 1'b1;
         default:                                hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/can_opb_slave.sv
// OPB slave front-end for the four-channel CAN interface.
// Decodes the CAN address window, issues single-cycle CAN_RE/CAN_WE strobes with a registered
// address and write data, waits RD_LAT edges before capturing CAN_DO, and closes each
// transaction with an OPB acknowledge. Illegal channel selects get an error acknowledge;
// addresses outside the window are ignored.
// Ports:
//   OPB_CLK, OPB_RST_N        - clock, asynchronous active-low reset
//   OPB_select/RNW/ABus/DBus  - OPB request, direction, address, write data
//   Sl_xferAck/errAck         - one-cycle acknowledge pulses
//   Sl_toutSup                - timeout suppress while a transaction is in flight
//   Sl_DBus                   - read data, zero whenever Sl_xferAck is low
//   CAN_ADDR/DI/RE/WE, CAN_DO - CAN interface address, write data, strobes, read data
module can_opb_slave
   import can_if_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
   parameter int unsigned RD_LAT     = 2              // legal range 1..15
) (
   input  logic        OPB_CLK,
   input  logic        OPB_RST_N,
   input  logic        OPB_select,
   input  logic        OPB_RNW,
   input  logic [31:0] OPB_ABus,
   input  logic [31:0] OPB_DBus,
   output logic        Sl_xferAck,
   output logic        Sl_errAck,
   output logic        Sl_toutSup,
   output logic [31:0] Sl_DBus,
   output logic [31:0] CAN_ADDR,
   output logic [31:0] CAN_DI,
   output logic        CAN_RE,
   output logic        CAN_WE,
   input  logic [31:0] CAN_DO
);

   // Loaded on the strobe-assert edge; reaching zero marks the CAN_DO capture edge.
   localparam logic [CNT_W-1:0] CntInit = CNT_W'(RD_LAT - 1);

   can_opb_state_e   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rnw_q, rnw_d;
   logic             ack_q, ack_d;
   logic             err_ack_q, err_ack_d;
   logic             tout_q, tout_d;
   logic [31:0]      dbus_q, dbus_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      di_q, di_d;
   logic             re_q, re_d;
   logic             we_q, we_d;

   logic in_window;
   logic sel_ok;

   assign in_window = OPB_select &&
                      (OPB_ABus[WIN_MSB:WIN_LSB] == C_BASEADDR[WIN_MSB:WIN_LSB]);
   assign sel_ok    = is_onehot4(OPB_ABus[SEL_MSB:SEL_LSB]);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rnw_d   = rnw_q;
      addr_d  = addr_q;
      di_d    = di_q;
      re_d    = 1'b0;
      we_d    = 1'b0;
      dbus_d  = 32'h0000_0000;

      unique case (state_q)
         StIdle: begin
            if (in_window) begin
               if (sel_ok) begin
                  state_d = StStb;
                  addr_d  = OPB_ABus;
                  di_d    = OPB_DBus;
                  rnw_d   = OPB_RNW;
                  re_d    = OPB_RNW;
                  we_d    = !OPB_RNW;
                  cnt_d   = CntInit;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StStb: begin
            if (!OPB_select) begin
               // Master abort: drop the transaction without an ack.
               state_d = StIdle;
            end else if (!rnw_q) begin
               state_d = StAck;
            end else if (cnt_q == '0) begin
               // RD_LAT == 1: capture straight out of the strobe cycle.
               state_d = StAck;
               dbus_d  = CAN_DO;
            end else begin
               state_d = StWait;
               cnt_d   = cnt_q - 1'b1;
            end
         end
         StWait: begin
            if (!OPB_select) begin
               state_d = StIdle;
            end else if (cnt_q == '0) begin
               state_d = StAck;
               dbus_d  = CAN_DO;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StAck, StErr: begin
            state_d = StDone;
         end
         StDone: begin
            // Select still high here belongs to the finished transaction.
            if (!OPB_select) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      ack_d     = (state_d == StAck) || (state_d == StErr);
      err_ack_d = (state_d == StErr);
      tout_d    = (state_d == StStb) || (state_d == StWait);
   end

   always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
      if (!OPB_RST_N) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         rnw_q     <= 1'b0;
         ack_q     <= 1'b0;
         err_ack_q <= 1'b0;
         tout_q    <= 1'b0;
         dbus_q    <= 32'h0000_0000;
         addr_q    <= 32'h0000_0000;
         di_q      <= 32'h0000_0000;
         re_q      <= 1'b0;
         we_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rnw_q     <= rnw_d;
         ack_q     <= ack_d;
         err_ack_q <= err_ack_d;
         tout_q    <= tout_d;
         dbus_q    <= dbus_d;
         addr_q    <= addr_d;
         di_q      <= di_d;
         re_q      <= re_d;
         we_q      <= we_d;
      end
   end

   assign Sl_xferAck = ack_q;
   assign Sl_errAck  = err_ack_q;
   assign Sl_toutSup = tout_q;
   assign Sl_DBus    = dbus_q;
   assign CAN_ADDR   = addr_q;
   assign CAN_DI     = di_q;
   assign CAN_RE     = re_q;
   assign CAN_WE     = we_q;

endmodule

// File: tb/tb_can_opb_slave.sv
// Self-checking bench for can_opb_slave (default parameters: base 0, RD_LAT 2).
// Inputs change and outputs are sampled on the falling clock edge. Each transaction that
// should be acknowledged pushes its expected {errAck, data} onto a scoreboard that a monitor
// pops whenever Sl_xferAck is seen.
module tb_can_opb_slave;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        rnw = 1'b0;
   logic [31:0] abus = 32'h0;
   logic [31:0] wdat = 32'h0;
   logic [31:0] can_do = 32'h0;

   logic        Sl_xferAck, Sl_errAck, Sl_toutSup, CAN_RE, CAN_WE;
   logic [31:0] Sl_DBus, CAN_ADDR, CAN_DI;
   logic [4:0]  ctl;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   can_opb_slave dut (
      .OPB_CLK    (clk),
      .OPB_RST_N  (rst_n),
      .OPB_select (sel),
      .OPB_RNW    (rnw),
      .OPB_ABus   (abus),
      .OPB_DBus   (wdat),
      .Sl_xferAck (Sl_xferAck),
      .Sl_errAck  (Sl_errAck),
      .Sl_toutSup (Sl_toutSup),
      .Sl_DBus    (Sl_DBus),
      .CAN_ADDR   (CAN_ADDR),
      .CAN_DI     (CAN_DI),
      .CAN_RE     (CAN_RE),
      .CAN_WE     (CAN_WE),
      .CAN_DO     (can_do)
   );

   // {ack, errAck, toutSup, RE, WE}
   assign ctl = {Sl_xferAck, Sl_errAck, Sl_toutSup, CAN_RE, CAN_WE};

   // Scoreboard monitor.
   always @(negedge clk) begin
      n_checks++;
      if (Sl_xferAck === 1'b1) begin
         if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL sb_unexpected_ack t=%0t: got err=%b data=%h, required no ack",
                     $time, Sl_errAck, Sl_DBus);
         end else begin
            mon_e = sb.pop_front();
            if ({Sl_errAck, Sl_DBus} !== {mon_e.err, mon_e.data}) begin
               n_errors++;
               $display("FAIL sb_ack_data t=%0t: got err=%b data=%h, required err=%b data=%h",
                        $time, Sl_errAck, Sl_DBus, mon_e.err, mon_e.data);
            end
         end
      end else if ({Sl_errAck, Sl_DBus} !== 33'h0) begin
         n_errors++;
         $display("FAIL sb_idle_bus t=%0t: got err=%b data=%h, required 0 without ack",
                  $time, Sl_errAck, Sl_DBus);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk_ctl(input string name, input logic [4:0] exp);
      n_checks++;
      if (ctl !== exp) begin
         n_errors++;
         $display("FAIL %s t=%0t: got ack/err/tout/re/we=%b, required %b", name, $time, ctl, exp);
      end
   endtask

   task automatic test_reset();
      step();
      n_checks++;
      if ({ctl, Sl_DBus, CAN_ADDR, CAN_DI} !== 101'h0) begin
         n_errors++;
         $display("FAIL reset_outputs: got ctl=%b dbus=%h addr=%h di=%h, required all 0",
                  ctl, Sl_DBus, CAN_ADDR, CAN_DI);
      end
      rst_n = 1'b1;
      step();
      chk_ctl("reset_idle", 5'b00000);
   endtask

   task automatic test_write();
      step();
      sel = 1'b1; rnw = 1'b0; abus = 32'h0000_0800; wdat = 32'h1234_5678;
      sb.push_back({1'b0, 32'h0});
      step();
      chk_ctl("wr_strobe", 5'b00101);
      n_checks++;
      if ({CAN_ADDR, CAN_DI} !== {32'h0000_0800, 32'h1234_5678}) begin
         n_errors++;
         $display("FAIL wr_addr_data: got addr=%h di=%h, required 00000800 12345678",
                  CAN_ADDR, CAN_DI);
      end
      step();
      chk_ctl("wr_ack", 5'b10000);
      sel = 1'b0;
      step();
      chk_ctl("wr_done", 5'b00000);
   endtask

   task automatic test_read();
      step();
      sel = 1'b1; rnw = 1'b1; abus = 32'h0000_2000; can_do = 32'hDEAD_BEEF;
      sb.push_back({1'b0, 32'h55AA_55AA});
      step();
      chk_ctl("rd_strobe", 5'b00110);
      step();
      chk_ctl("rd_wait", 5'b00100);
      can_do = 32'h55AA_55AA;   // valid only around the capture edge
      step();
      chk_ctl("rd_ack", 5'b10000);
      can_do = 32'h0BAD_0BAD;
      n_checks++;
      if (Sl_DBus !== 32'h55AA_55AA) begin
         n_errors++;
         $display("FAIL rd_data: got %h, required 55aa55aa", Sl_DBus);
      end
      sel = 1'b0;
      step();
      chk_ctl("rd_done", 5'b00000);
   endtask

   task automatic test_bad_select();
      logic [31:0] addrs [2];
      addrs[0] = 32'h0000_1800;
      addrs[1] = 32'h0000_0000;
      for (int i = 0; i < 2; i++) begin
         step();
         sel = 1'b1; rnw = 1'b1; abus = addrs[i];
         sb.push_back({1'b1, 32'h0});
         step();
         chk_ctl("err_ack", 5'b11000);
         n_checks++;
         if (CAN_ADDR !== 32'h0000_2000) begin
            n_errors++;
            $display("FAIL err_addr_hold: got %h, required 00002000", CAN_ADDR);
         end
         sel = 1'b0;
         step();
         chk_ctl("err_done", 5'b00000);
      end
   endtask

   task automatic test_out_of_window();
      step();
      sel = 1'b1; rnw = 1'b0; abus = 32'h0001_0800; wdat = 32'hFFFF_0000;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_ctl("oow_quiet", 5'b00000);
      end
      n_checks++;
      if (CAN_DI !== 32'h1234_5678) begin
         n_errors++;
         $display("FAIL oow_di_hold: got %h, required 12345678", CAN_DI);
      end
      sel = 1'b0;
   endtask

   task automatic test_abort();
      step();
      sel = 1'b1; rnw = 1'b1; abus = 32'h0000_4000; can_do = 32'h7777_7777;
      step();
      chk_ctl("abort_strobe", 5'b00110);
      sel = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_ctl("abort_no_ack", 5'b00000);
      end
      sel = 1'b1; rnw = 1'b0; abus = 32'h0000_0804; wdat = 32'hCAFE_0001;
      sb.push_back({1'b0, 32'h0});
      step();
      chk_ctl("abort_wr_strobe", 5'b00101);
      step();
      chk_ctl("abort_wr_ack", 5'b10000);
      sel = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      int we_cnt = 0;
      int ack_cnt = 0;
      step();
      sel = 1'b1; rnw = 1'b0; abus = 32'h0000_0800; wdat = 32'hAAAA_0000;
      sb.push_back({1'b0, 32'h0});
      for (int i = 0; i < 6; i++) begin
         step();
         we_cnt  += int'(CAN_WE);
         ack_cnt += int'(Sl_xferAck);
      end
      sel = 1'b0;
      step();
      step();
      n_checks++;
      if (we_cnt != 1 || ack_cnt != 1) begin
         n_errors++;
         $display("FAIL hold_single_xfer: got we=%0d ack=%0d, required 1 and 1", we_cnt, ack_cnt);
      end
   endtask

   task automatic test_reset_mid();
      step();
      sel = 1'b1; rnw = 1'b1; abus = 32'h0000_0800; wdat = 32'h3333_4444;
      can_do = 32'h1111_2222;
      step();
      step();
      chk_ctl("rstmid_wait", 5'b00100);
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ctl, Sl_DBus, CAN_ADDR, CAN_DI} !== 101'h0) begin
         n_errors++;
         $display("FAIL rstmid_clear: got ctl=%b dbus=%h addr=%h di=%h, required all 0",
                  ctl, Sl_DBus, CAN_ADDR, CAN_DI);
      end
      sel = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      sel = 1'b1; rnw = 1'b1; abus = 32'h0000_0800; can_do = 32'hC0FF_EE01;
      sb.push_back({1'b0, 32'hC0FF_EE01});
      step();
      chk_ctl("rstmid_rd_strobe", 5'b00110);
      step();
      chk_ctl("rstmid_rd_wait", 5'b00100);
      step();
      chk_ctl("rstmid_rd_ack", 5'b10000);
      sel = 1'b0;
      step();
      chk_ctl("rstmid_rd_done", 5'b00000);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_bad_select();
      test_out_of_window();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      step();
      step();
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL sb_drain: got %0d pending acks, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
